// File: rtl/mcs4.sv
// Shared MCS-4 bus types.
package mcs4;
  typedef logic [3:0] char_t;
endpackage

// File: rtl/i4001_rom_if.sv
// CPU-side control lines plus the shared 4-bit data bus, as seen by one 4001 chip.
interface i4001_rom_if;
  logic        sync;
  logic        cm_rom;
  mcs4::char_t dbus_in;
  mcs4::char_t dbus_out;
  logic        dbus_oe;

  modport master (output sync, output cm_rom, output dbus_in, input dbus_out, input dbus_oe);
  modport slave  (input sync, input cm_rom, input dbus_in, output dbus_out, output dbus_oe);
endinterface

// File: rtl/i4001_rom.sv
// 4001-style 256x8 program ROM with a 4-bit I/O port, following the MCS-4 eight-phase bus cycle.
module i4001_rom #(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter logic [3:0] IO_DIR  = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  i4001_rom_if.slave       bus,
  input  logic [3:0]       io_in,
  output logic [3:0]       io_out,
  input  logic             prog_we,
  input  logic [7:0]       prog_addr,
  input  logic [7:0]       prog_data
);

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

  phase_t      phase, phase_next;
  logic        synced;
  logic [7:0]  addr;
  logic        chip_sel, src_sel, is_instr2;
  mcs4::char_t opr, opa;
  logic [7:0]  fetch_buf;
  logic [7:0]  rom [256];

  logic realign, first_word, x2_active, do_src, do_wrr, do_rdr, opr_two_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= A1;
      synced <= 1'b0;
    end else begin
      phase <= phase_next;
      if (bus.sync) synced <= 1'b1;
    end
  end

  always_comb begin
    phase_next = A1;
    unique case (phase)
      A1: phase_next = A2;
      A2: phase_next = A3;
      A3: phase_next = M1;
      M1: phase_next = M2;
      M2: phase_next = X1;
      X1: phase_next = X2;
      X2: phase_next = X3;
      X3: phase_next = A1;
      default: phase_next = A1;
    endcase
    if (bus.sync) phase_next = A1;

    // A sync anywhere but X3 means we lost alignment; the X2 slot of that cycle is not trusted.
    realign      = bus.sync && (phase != X3);
    first_word   = !is_instr2;
    x2_active    = synced && (phase == X2) && !bus.sync;
    do_src       = x2_active && first_word && (opr == 4'h2) && opa[0];
    do_wrr       = x2_active && first_word && (opr == 4'hE) && (opa == 4'h2);
    do_rdr       = x2_active && first_word && (opr == 4'hE) && (opa == 4'hA);
    opr_two_word = (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
                   ((opr == 4'h2) && !opa[0]);

    bus.dbus_oe  = 1'b0;
    bus.dbus_out = 4'h0;
    if (synced && chip_sel && (phase == M1)) begin
      bus.dbus_oe  = 1'b1;
      bus.dbus_out = fetch_buf[7:4];
    end
    if (synced && chip_sel && (phase == M2)) begin
      bus.dbus_oe  = 1'b1;
      bus.dbus_out = fetch_buf[3:0];
    end
    if (do_rdr && src_sel) begin
      bus.dbus_oe  = 1'b1;
      bus.dbus_out = (io_in & ~IO_DIR) | (io_out & IO_DIR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= 8'h00;
      chip_sel  <= 1'b0;
      src_sel   <= 1'b0;
      is_instr2 <= 1'b0;
      opr       <= 4'h0;
      opa       <= 4'h0;
      io_out    <= 4'h0;
    end else if (synced) begin
      case (phase)
        A1: addr[3:0] <= bus.dbus_in;
        A2: addr[7:4] <= bus.dbus_in;
        A3: chip_sel  <= (bus.dbus_in == CHIP_ID) && bus.cm_rom;
        M1: opr       <= bus.dbus_in;
        M2: opa       <= bus.dbus_in;
        X3: is_instr2 <= first_word && opr_two_word;
        default: ;
      endcase
      if (do_src && bus.cm_rom) src_sel <= (bus.dbus_in == CHIP_ID);
      if (do_wrr && src_sel) io_out <= bus.dbus_in & IO_DIR;
      if (realign) begin
        chip_sel  <= 1'b0;
        is_instr2 <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset so a program survives a CPU reset; the A3 read sees the pre-write byte.
  always_ff @(posedge clk) begin
    if (prog_we) rom[prog_addr] <= prog_data;
    if (synced && (phase == A3)) fetch_buf <= rom[addr];
  end

endmodule

// File: tb/tb_i4001_rom.sv
// Two 4001 chips (IDs 3 and 4) on one bus, driven by a CPU-like stimulus and checked per instruction cycle.
module tb_i4001_rom;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i4001_rom_if bus3 ();
  i4001_rom_if bus4 ();

  logic       cpu_sync, cpu_cm, cpu_drv;
  logic [3:0] cpu_val, bus_val;
  logic [3:0] io_in3, io_in4, io_out3, io_out4;
  logic       prog_we;
  logic [7:0] prog_addr, prog_data3, prog_data4;

  assign bus_val      = (cpu_drv ? cpu_val : 4'h0) | bus3.dbus_out | bus4.dbus_out;
  assign bus3.sync    = cpu_sync;
  assign bus4.sync    = cpu_sync;
  assign bus3.cm_rom  = cpu_cm;
  assign bus4.cm_rom  = cpu_cm;
  assign bus3.dbus_in = bus_val;
  assign bus4.dbus_in = bus_val;

  i4001_rom #(.CHIP_ID(4'h3), .IO_DIR(4'b1111)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .io_in(io_in3), .io_out(io_out3),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data3));

  i4001_rom #(.CHIP_ID(4'h4), .IO_DIR(4'b0011)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .io_in(io_in4), .io_out(io_out4),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data4));

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  logic [7:0] rom_m [2][256];
  logic       src_sel_m [2];
  logic [3:0] io_m [2];
  logic       instr2_m;

  function automatic logic [3:0] id_of(input int k);
    return (k == 0) ? 4'h3 : 4'h4;
  endfunction

  function automatic logic [3:0] dir_of(input int k);
    return (k == 0) ? 4'b1111 : 4'b0011;
  endfunction

  function automatic logic [9:0] driveOf(input int k, input logic [3:0] v);
    if (k == 0) return {1'b1, v, 5'b0};
    if (k == 1) return {5'b0, 1'b1, v};
    return 10'd0;
  endfunction

  function automatic logic [7:0] pickByte();
    logic [3:0] r;
    r = 4'($urandom);
    case ($urandom_range(0, 9))
      0: return {4'h2, r[3:1], 1'b1};
      1: return 8'hE2;
      2: return 8'hEA;
      3: return {4'h4, r};
      4: return {4'h1, r};
      5: return {4'h2, r[3:1], 1'b0};
      6: return {4'h5, r};
      7: return {4'h7, r};
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One bus phase: drive right after the edge, compare mid-cycle, return just after the next edge.
  task automatic applyStimulus(input logic s, input logic cm, input logic drv, input logic [3:0] v,
                               input logic r, input logic [9:0] exp_drive, input string tag);
    cpu_sync = s;
    cpu_cm   = cm;
    cpu_drv  = drv;
    cpu_val  = v;
    rst      = r;
    @(negedge clk);
    checkOutput(tag, {22'd0, bus3.dbus_oe, bus3.dbus_out, bus4.dbus_oe, bus4.dbus_out}, {22'd0, exp_drive});
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      src_sel_m[k] = 1'b0;
      io_m[k]      = 4'h0;
    end
    instr2_m = 1'b0;
  endtask

  // Plays one instruction cycle; abort_at < 7 raises sync early in that phase and abandons the cycle.
  task automatic runCycle(input logic [7:0] addr, input logic [3:0] a3_nib, input logic cm3,
                          input logic [3:0] x2_nib, input logic cm_x2, input logic [7:0] free_word,
                          input int abort_at);
    int         sel, rdr_chip;
    logic [7:0] word;
    logic       first, is_src, is_wrr, is_rdr;
    logic [3:0] rdr_in;
    logic [9:0] x2_exp;
    sel = -1;
    if (cm3 && a3_nib == 4'h3) sel = 0;
    else if (cm3 && a3_nib == 4'h4) sel = 1;
    word   = (sel >= 0) ? rom_m[sel][addr] : free_word;
    first  = !instr2_m;
    is_src = first && (word[7:4] == 4'h2) && word[0];
    is_wrr = first && (word == 8'hE2);
    is_rdr = first && (word == 8'hEA);
    rdr_chip = -1;
    for (int k = 0; k < 2; k++) if (is_rdr && src_sel_m[k]) rdr_chip = k;
    x2_exp = 10'd0;
    if (rdr_chip >= 0) begin
      rdr_in = (rdr_chip == 0) ? io_in3 : io_in4;
      x2_exp = driveOf(rdr_chip, (rdr_in & ~dir_of(rdr_chip)) | (io_m[rdr_chip] & dir_of(rdr_chip)));
    end
    for (int p = 0; p < 8; p++) begin
      logic       s, cm, drv;
      logic [3:0] v;
      logic [9:0] e;
      s = (p == 7) || (p == abort_at);
      cm = 1'b0; drv = 1'b1; v = 4'($urandom); e = 10'd0;
      case (p)
        0: v = addr[3:0];
        1: v = addr[7:4];
        2: begin v = a3_nib; cm = cm3; end
        3: begin drv = (sel < 0); v = word[7:4]; e = driveOf(sel, word[7:4]); end
        4: begin drv = (sel < 0); v = word[3:0]; e = driveOf(sel, word[3:0]); end
        6: begin cm = cm_x2; drv = (rdr_chip < 0); v = x2_nib; e = x2_exp; end
        default: ;
      endcase
      applyStimulus(s, cm, drv, v, 1'b0, e, $sformatf("cyc%0d_ph%0d", cycle_no, p));
      if (p == abort_at) break;
    end
    if (abort_at < 7) begin
      instr2_m = 1'b0;
    end else begin
      if (is_src && cm_x2)
        for (int k = 0; k < 2; k++) src_sel_m[k] = (x2_nib == id_of(k));
      if (is_wrr)
        for (int k = 0; k < 2; k++) if (src_sel_m[k]) io_m[k] = x2_nib & dir_of(k);
      instr2_m = first && ((word[7:4] == 4'h1) || (word[7:4] == 4'h4) || (word[7:4] == 4'h5) ||
                           (word[7:4] == 4'h7) || ((word[7:4] == 4'h2) && !word[0]));
    end
    checkOutput($sformatf("cyc%0d_io_out3", cycle_no), {28'd0, io_out3}, {28'd0, io_m[0]});
    checkOutput($sformatf("cyc%0d_io_out4", cycle_no), {28'd0, io_out4}, {28'd0, io_m[1]});
    cycle_no++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] pat [8];
    logic [3:0] a3, x2;
    logic       cm3, cmx2;
    int         ab;
    pat = '{4'hA, 4'h5, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rst = 1'b1;
    cpu_sync = 1'b0; cpu_cm = 1'b0; cpu_drv = 1'b0; cpu_val = 4'h0;
    io_in3 = 4'h0; io_in4 = 4'h0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data3 = 8'h00; prog_data4 = 8'h00;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_drive", {22'd0, bus3.dbus_oe, bus3.dbus_out, bus4.dbus_oe, bus4.dbus_out}, 32'd0);
    checkOutput("reset_io_out3", {28'd0, io_out3}, 32'd0);
    checkOutput("reset_io_out4", {28'd0, io_out4}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) rom_m[k][a] = pickByte();
    rom_m[0][8'h5A] = 8'h3C;
    rom_m[0][8'h10] = 8'h21;
    rom_m[0][8'h11] = 8'hE2;
    rom_m[0][8'h12] = 8'hEA;
    rom_m[0][8'h13] = 8'h40;
    for (int a = 0; a < 256; a++) begin
      prog_we = 1'b1; prog_addr = 8'(a);
      prog_data3 = rom_m[0][a]; prog_data4 = rom_m[1][a];
      @(posedge clk);
      #1;
    end
    prog_we = 1'b0;

    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, pat[i % 8], 1'b0, 10'd0, $sformatf("unsynced_%0d", i));
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 10'd0, "first_sync");

    runCycle(8'h5A, 4'h3, 1'b1, 4'h0, 1'b0, 8'hF0, 7);
    runCycle(8'h5A, 4'h2, 1'b1, 4'h0, 1'b0, 8'hF0, 7);
    runCycle(8'h10, 4'h3, 1'b1, 4'h3, 1'b1, 8'hF0, 7);
    runCycle(8'h11, 4'h3, 1'b1, 4'h9, 1'b0, 8'hF0, 7);
    runCycle(8'h10, 4'h3, 1'b1, 4'h4, 1'b1, 8'hF0, 7);
    runCycle(8'h11, 4'h3, 1'b1, 4'h3, 1'b0, 8'hF0, 7);
    io_in4 = 4'hC;
    runCycle(8'h12, 4'h3, 1'b1, 4'h0, 1'b0, 8'hF0, 7);
    runCycle(8'h13, 4'h3, 1'b1, 4'h0, 1'b0, 8'hF0, 7);
    runCycle(8'h10, 4'h3, 1'b1, 4'h3, 1'b1, 8'hF0, 7);
    runCycle(8'h11, 4'h3, 1'b1, 4'hA, 1'b0, 8'hF0, 7);
    runCycle(8'h13, 4'h3, 1'b1, 4'h0, 1'b0, 8'hF0, 7);
    runCycle(8'h5A, 4'h3, 1'b1, 4'h0, 1'b0, 8'hF0, 1);
    runCycle(8'h10, 4'h3, 1'b1, 4'h3, 1'b1, 8'hF0, 7);
    runCycle(8'h11, 4'h3, 1'b1, 4'h5, 1'b0, 8'hF0, 7);

    for (int i = 0; i < 200; i++) begin
      io_in3 = 4'($urandom);
      io_in4 = 4'($urandom);
      a3   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'h3 : 4'h4);
      cm3  = ($urandom_range(0, 7) != 0);
      x2   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'h3 : 4'h4);
      cmx2 = ($urandom_range(0, 3) != 0);
      ab   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 5)) : 7;
      runCycle(8'($urandom), a3, cm3, x2, cmx2, pickByte(), ab);
    end

    // Reset in the middle of a selected fetch: M1 drive is still up, gone one clock later.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 10'd0, "rstfetch_a1");
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 10'd0, "rstfetch_a2");
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 10'd0, "rstfetch_a3");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, driveOf(0, 4'h3), "rstfetch_m1");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 10'd0, "rstfetch_after");
    modelReset();
    checkOutput("rstfetch_io_out3", {28'd0, io_out3}, 32'd0);
    checkOutput("rstfetch_io_out4", {28'd0, io_out4}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 10'd0, "resync");
    runCycle(8'h5A, 4'h3, 1'b1, 4'h0, 1'b0, 8'hF0, 7);
    runCycle(8'h10, 4'h3, 1'b1, 4'h4, 1'b1, 8'hF0, 7);
    runCycle(8'h11, 4'h3, 1'b1, 4'h7, 1'b0, 8'hF0, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
